// File: rtl/stopwatch_display.sv
// Binary mm:ss to BCD, time-multiplexed onto a 4-digit common-anode 7-segment display,
// with adjust-mode blinking of one digit pair. Define DP_COLON_EN to light the min-ones dp.
module stopwatch_display #(
    parameter int SCAN_DIV  = 100000,
    parameter int BLINK_DIV = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] mincounter,
    input  logic [5:0] seccounter,
    input  logic       adj,
    input  logic       sel,
    output logic [7:0] seg,
    output logic [3:0] an
);

    localparam int SCAN_W  = $clog2(SCAN_DIV);
    localparam int BLINK_W = $clog2(BLINK_DIV);
    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    logic [SCAN_W-1:0]  scan_cnt;
    logic [1:0]         digit;
    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_phase;
    logic [5:0]         snap_min;
    logic [5:0]         snap_sec;

    logic               scan_tc;
    logic               blink_tc;
    logic [3:0]         bcd;
    logic               blank;
    logic [3:0]         an_nxt;
    logic [7:0]         seg_nxt;

    function automatic logic [3:0] bcd_tens(input logic [5:0] v);
        return 4'(v / 6'd10);
    endfunction

    function automatic logic [3:0] bcd_ones(input logic [5:0] v);
        return 4'(v % 6'd10);
    endfunction

    // gfedcba, active-low
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    always_comb begin
        scan_tc  = (scan_cnt == SCAN_LAST);
        blink_tc = (blink_cnt == BLINK_LAST);
        an_nxt   = ~(4'b0001 << digit);
        case (digit)
            2'd0:    bcd = bcd_ones(snap_sec);
            2'd1:    bcd = bcd_tens(snap_sec);
            2'd2:    bcd = bcd_ones(snap_min);
            default: bcd = bcd_tens(snap_min);
        endcase
        // blink_phase can only be set while adj is high, so it alone gates blanking;
        // after adj drops the digits return once the cleared phase reaches the output.
        blank = blink_phase && (sel ? !digit[1] : digit[1]);
        seg_nxt[6:0] = blank ? 7'h7F : seg_decode(bcd);
`ifdef DP_COLON_EN
        seg_nxt[7] = (digit != 2'd2);
`else
        seg_nxt[7] = 1'b1;
`endif
    end

    // Scan / snapshot / blink state, then registered pin outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt    <= '0;
            digit       <= 2'd0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            snap_min    <= 6'd0;
            snap_sec    <= 6'd0;
            an          <= 4'b1111;
            seg         <= 8'hFF;
        end else begin
            scan_cnt <= scan_tc ? '0 : scan_cnt + 1'b1;
            if (scan_tc) begin
                digit <= digit + 2'd1;
                // Sample inputs only at frame start so a frame never mixes two values
                if (digit == 2'd3) begin
                    snap_min <= mincounter;
                    snap_sec <= seccounter;
                end
            end
            if (!adj) begin
                blink_cnt   <= '0;
                blink_phase <= 1'b0;
            end else begin
                blink_cnt <= blink_tc ? '0 : blink_cnt + 1'b1;
                if (blink_tc)
                    blink_phase <= ~blink_phase;
            end
            an  <= an_nxt;
            seg <= seg_nxt;
        end
    end

endmodule

// File: tb/tb_stopwatch_display.sv
// Bench for stopwatch_display (SCAN_DIV=4, BLINK_DIV=16): vector table plus hand sequences,
// with a per-cycle scoreboard of expected {an, seg}.
module tb_stopwatch_display;

    localparam int SCAN_DIV  = 4;
    localparam int BLINK_DIV = 16;
    localparam int FRAME     = 16;
`ifdef DP_COLON_EN
    localparam bit DP_EN = 1'b1;
`else
    localparam bit DP_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] mincounter = 6'd0;
    logic [5:0] seccounter = 6'd0;
    logic       adj = 1'b0;
    logic       sel = 1'b0;
    logic [7:0] seg;
    logic [3:0] an;

    stopwatch_display #(.SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV)) dut (
        .clk(clk), .rst(rst), .mincounter(mincounter), .seccounter(seccounter),
        .adj(adj), .sel(sel), .seg(seg), .an(an)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] an;
        logic [7:0] seg;
        bit         chk;
    } exp_t;

    typedef struct {
        logic [5:0] mn;
        logic [5:0] sc;
        logic [6:0] s0;  // sec ones
        logic [6:0] s1;  // sec tens
        logic [6:0] s2;  // min ones
        logic [6:0] s3;  // min tens
    } vec_t;

    exp_t       sbq[$];
    int         vec_cnt = 0;
    int         err_cnt = 0;
    int         n = 0;
    logic [3:0] an_of [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    task automatic tick();
        @(posedge clk);
        #1;
        n++;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic dp_exp(input int d);
        return !(DP_EN && d == 2);
    endfunction

    task automatic push_digit(input int d, input logic [6:0] s, input int cnt, input bit chk_en);
        exp_t e;
        e.an  = an_of[d];
        e.seg = {dp_exp(d), s};
        e.chk = chk_en;
        repeat (cnt) sbq.push_back(e);
    endtask

    task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3,
                              input bit blank_sec, input bit blank_min);
        push_digit(0, blank_sec ? 7'h7F : s0, 4, 1'b1);
        push_digit(1, blank_sec ? 7'h7F : s1, 4, 1'b1);
        push_digit(2, blank_min ? 7'h7F : s2, 4, 1'b1);
        push_digit(3, blank_min ? 7'h7F : s3, 4, 1'b1);
    endtask

    task automatic check_cycles(input int cnt);
        exp_t e;
        for (int i = 0; i < cnt; i++) begin
            tick();
            if (sbq.size() == 0) begin
                vec_cnt++;
                err_cnt++;
                $display("FAIL scoreboard: no expected entry at t=%0t", $time);
            end else begin
                e = sbq.pop_front();
                if (e.chk) begin
                    chk("an", {4'b0, an}, {4'b0, e.an});
                    chk("seg", seg, e.seg);
                end
            end
        end
    endtask

    // Advance to the next snapshot edge (frame boundary counted from reset release)
    task automatic align();
        do tick(); while (n % FRAME != 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl [7];
        tbl[0] = '{6'd12, 6'd34, 7'h19, 7'h30, 7'h24, 7'h79};
        tbl[1] = '{6'd0,  6'd0,  7'h40, 7'h40, 7'h40, 7'h40};
        tbl[2] = '{6'd63, 6'd63, 7'h30, 7'h02, 7'h30, 7'h02};
        tbl[3] = '{6'd59, 6'd8,  7'h00, 7'h40, 7'h10, 7'h12};
        tbl[4] = '{6'd7,  6'd59, 7'h10, 7'h12, 7'h78, 7'h40};
        tbl[5] = '{6'd60, 6'd61, 7'h79, 7'h02, 7'h40, 7'h02};
        tbl[6] = '{6'd45, 6'd26, 7'h02, 7'h24, 7'h12, 7'h19};

        // Reset held for 3 clocks, then first digit appears one clock after release
        rst = 1'b1;
        repeat (3) begin
            tick();
            chk("rst_an", {4'b0, an}, 8'h0F);
            chk("rst_seg", seg, 8'hFF);
        end
        rst = 1'b0;
        n = 0;
        tick();
        chk("post_rst_an", {4'b0, an}, 8'h0E);
        chk("post_rst_seg", seg, 8'hC0);

        for (int v = 0; v < 7; v++) begin
            mincounter = tbl[v].mn;
            seccounter = tbl[v].sc;
            align();
            push_frame(tbl[v].s0, tbl[v].s1, tbl[v].s2, tbl[v].s3, 1'b0, 1'b0);
            check_cycles(FRAME);
        end

        // Input change mid-frame must wait for the next frame
        mincounter = 6'd12;
        seccounter = 6'd34;
        align();
        push_frame(7'h19, 7'h30, 7'h24, 7'h79, 1'b0, 1'b0);
        check_cycles(2);
        seccounter = 6'd35;
        check_cycles(FRAME - 2);
        push_frame(7'h12, 7'h30, 7'h24, 7'h79, 1'b0, 1'b0);
        check_cycles(FRAME);

        // Adjust mode blinking the seconds pair, then adj released mid-blank
        mincounter = 6'd7;
        seccounter = 6'd59;
        align();
        adj = 1'b1;
        sel = 1'b1;
        push_frame(7'h10, 7'h12, 7'h78, 7'h40, 1'b0, 1'b0);
        check_cycles(FRAME);
        push_frame(7'h10, 7'h12, 7'h78, 7'h40, 1'b1, 1'b0);
        check_cycles(FRAME);
        push_frame(7'h10, 7'h12, 7'h78, 7'h40, 1'b0, 1'b0);
        check_cycles(FRAME);
        push_digit(0, 7'h7F, 4, 1'b1);
        push_digit(1, 7'h7F, 2, 1'b1);
        push_digit(1, 7'h7F, 1, 1'b0);
        push_digit(1, 7'h12, 1, 1'b1);
        push_digit(2, 7'h78, 4, 1'b1);
        push_digit(3, 7'h40, 4, 1'b1);
        check_cycles(6);
        adj = 1'b0;
        check_cycles(10);
        push_frame(7'h10, 7'h12, 7'h78, 7'h40, 1'b0, 1'b0);
        check_cycles(FRAME);

        // Reset while digit=2 with blink phase set: scan, snapshot and blink all restart
        sel = 1'b0;
        mincounter = 6'd45;
        seccounter = 6'd26;
        adj = 1'b1;
        repeat (25) tick();
        rst = 1'b1;
        tick();
        chk("midrst_an", {4'b0, an}, 8'h0F);
        chk("midrst_seg", seg, 8'hFF);
        rst = 1'b0;
        n = 0;
        push_frame(7'h40, 7'h40, 7'h40, 7'h40, 1'b0, 1'b0);
        check_cycles(FRAME);
        push_frame(7'h02, 7'h24, 7'h12, 7'h19, 1'b0, 1'b1);
        check_cycles(FRAME);
        adj = 1'b0;
        repeat (2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
